ssm_word_scheduler: RTL and testbench

Schedules 128-bit mux words from the single-read-port bitstream buffer into the four substream parsers (ssm0 = bitparse, ssm1..3 = bitparse_ssm123). The block replaces the bench-side combinational address/offset logic with a registered, order-preserving demultiplexer. Each parser gets a show-ahead prefetch FIFO and can pop one word per cycle with zero latency. The scheduler refills these FIFOs from the buffer in consumption order, so the word-to-substream assignment matches the encoder's mux model.

---
 rtl/vdcm_ssm_pkg.sv | 17 +
 rtl/ssm_fifo.sv | 68 ++++++
 rtl/ssm_word_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_ssm_word_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdcm_ssm_pkg.sv
// rtl/vdcm_ssm_pkg.sv - shared types and constants for the substream word scheduler
// Contents: N_SSM (substream count), WORD_W (mux word width),
//           ssm_id_t (substream id), sched_state_t (scheduler state).
package vdcm_ssm_pkg;

  localparam int N_SSM  = 4;
  localparam int WORD_W = 128;

  typedef logic [1:0] ssm_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/ssm_fifo.sv
// rtl/ssm_fifo.sv - synchronous show-ahead word FIFO for one substream parser
// Ports:
//   clk, rst     clock, synchronous active-high reset (also zeroes storage)
//   clr          synchronous flush of pointers/occupancy (storage kept)
//   push, din    write one word (ignored when full unless popping too)
//   pop          remove head word (ignored when empty)
//   dout         head word; while empty it holds the most recently popped word
//   vld          FIFO non-empty
//   full         FIFO at DEPTH entries
module ssm_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != DEPTH_C) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When empty, show the slot just behind the read pointer: that is the word
  // that was last at the head, so the output does not jump to stale storage.
  assign vld  = (count != '0);
  assign full = (count == DEPTH_C);
  assign dout = vld ? mem[rd_ptr] : mem[rd_ptr - 1'b1];

endmodule

// File: rtl/ssm_word_scheduler.sv
// rtl/ssm_word_scheduler.sv - order-preserving demux of buffer words into four substream FIFOs
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_dec         start / restart pulse
//   buf_words_avail   unread words in the bitstream buffer
//   mem_rd_en/addr    buffer read strobe and address (each read consumes a word)
//   mem_rd_data       read data, one cycle after mem_rd_en
//   ssm_rd_en[3:0]    per-substream pop
//   ssm_data          head words, ssm0 in the LSBs
//   ssm_vld[3:0]      head word valid
//   busy              scheduler not idle
//   err[3:0]          sticky per-substream error flags
// Optional feature macro: SSM_SCHED_ERR_CHK_EN enables the err checks
// (pop-while-empty, write-while-full, queue overflow); otherwise err is 0.
module ssm_word_scheduler
  import vdcm_ssm_pkg::*;
#(
  parameter int WORD_W      = 128,
  parameter int AW          = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_WORDS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_dec,
  input  logic [AW:0]             buf_words_avail,
  output logic                    mem_rd_en,
  output logic [AW-1:0]           mem_rd_addr,
  input  logic [WORD_W-1:0]       mem_rd_data,
  input  logic [N_SSM-1:0]        ssm_rd_en,
  output logic [N_SSM*WORD_W-1:0] ssm_data,
  output logic [N_SSM-1:0]        ssm_vld,
  output logic                    busy,
  output logic [N_SSM-1:0]        err
);

  localparam int QD      = N_SSM * FIFO_DEPTH;
  localparam int QPW     = $clog2(QD);
  localparam int PRIME_N = N_SSM * PRIME_WORDS;
  localparam int PCW     = $clog2(PRIME_N + 1);

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic [AW-1:0]       rd_addr;
  logic [PCW-1:0]      prime_cnt;
  logic                infl_vld;
  ssm_id_t             infl_id;
  logic                can_issue;
  logic                issue;
  ssm_id_t             issue_id;
  logic                deq;

  ssm_id_t             q_mem [QD];
  logic [QPW-1:0]      q_wr;
  logic [QPW-1:0]      q_rd;
  logic [QPW:0]        q_cnt;
  logic [N_SSM-1:0]    pop_ok;
  logic [N_SSM-1:0]    pop_eff;
  logic [2:0]          enq_off [N_SSM];
  logic [2:0]          n_enq;

  logic [N_SSM-1:0]    fifo_push;
  logic [N_SSM-1:0]    fifo_full;
  logic [WORD_W-1:0]   head [N_SSM];

  // Only pops of a valid head are real; the rest are dropped (and flagged).
  assign pop_ok  = ssm_rd_en & ssm_vld;
  assign pop_eff = (state != IDLE && !start_dec) ? pop_ok : '0;

  // One read may still be unacknowledged, and the buffer count does not yet
  // reflect it, so it must be reserved.
  assign can_issue = buf_words_avail > (AW+1)'(infl_vld);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_id  = '0;
    case (state)
      IDLE: begin
        if (start_dec) state_nxt = PRIME;
      end
      PRIME: begin
        issue    = can_issue;
        issue_id = prime_cnt[1:0];
        if (issue && prime_cnt == PCW'(PRIME_N - 1)) state_nxt = RUN;
      end
      RUN: begin
        issue    = can_issue && (q_cnt != '0);
        issue_id = q_mem[q_rd];
      end
      default: state_nxt = IDLE;
    endcase
    // Restart wins over everything else in the cycle.
    if (start_dec) begin
      state_nxt = PRIME;
      issue     = 1'b0;
    end
  end

  assign deq = issue && (state == RUN);

  // Same-cycle pops are packed into the queue in ascending substream order.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < N_SSM; i++) begin
      enq_off[i] = n_enq;
      if (pop_eff[i]) n_enq = n_enq + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      prime_cnt <= '0;
      infl_vld  <= 1'b0;
      infl_id   <= '0;
    end else begin
      state <= state_nxt;
      if (start_dec) begin
        rd_addr   <= '0;
        prime_cnt <= '0;
        infl_vld  <= 1'b0;
      end else begin
        infl_vld <= issue;
        infl_id  <= issue_id;
        if (issue) rd_addr <= rd_addr + 1'b1;
        if (issue && state == PRIME) prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_dec) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      for (int i = 0; i < N_SSM; i++) begin
        if (pop_eff[i]) q_mem[q_wr + QPW'(enq_off[i])] <= ssm_id_t'(i);
      end
      q_wr <= q_wr + QPW'(n_enq);
      if (deq) q_rd <= q_rd + 1'b1;
      q_cnt <= q_cnt + (QPW+1)'(n_enq) - (QPW+1)'(deq);
    end
  end

  for (genvar g = 0; g < N_SSM; g++) begin : g_fifo
    // A return arriving in a restart cycle belongs to the old stream; drop it.
    assign fifo_push[g] = infl_vld && (infl_id == ssm_id_t'(g)) && !start_dec &&
                          (!fifo_full[g] || pop_ok[g]);

    ssm_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_dec),
      .push (fifo_push[g]),
      .din  (mem_rd_data),
      .pop  (pop_ok[g]),
      .dout (head[g]),
      .vld  (ssm_vld[g]),
      .full (fifo_full[g])
    );

    assign ssm_data[g*WORD_W +: WORD_W] = head[g];
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_addr;
  assign busy        = (state != IDLE);

`ifdef SSM_SCHED_ERR_CHK_EN
  logic [N_SSM-1:0] err_q;
  logic [N_SSM-1:0] err_set;
  logic [N_SSM-1:0] wr_full;
  logic [QPW+1:0]   q_cnt_nxt;
  logic             q_ovf;

  for (genvar g = 0; g < N_SSM; g++) begin : g_wr_full
    assign wr_full[g] = infl_vld && (infl_id == ssm_id_t'(g)) && !start_dec &&
                        fifo_full[g] && !pop_ok[g];
  end

  assign q_cnt_nxt = {1'b0, q_cnt} + (QPW+2)'(n_enq) - (QPW+2)'(deq);
  assign q_ovf     = q_cnt_nxt > (QPW+2)'(QD);
  assign err_set   = (ssm_rd_en & ~ssm_vld) | wr_full | (q_ovf ? pop_eff : '0);

  always_ff @(posedge clk) begin
    if (rst || start_dec) err_q <= '0;
    else                  err_q <= err_q | err_set;
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_ssm_word_scheduler.sv
// tb/tb_ssm_word_scheduler.sv - scoreboard bench for the substream word scheduler
module tb_ssm_word_scheduler;
  import vdcm_ssm_pkg::*;

  localparam int W   = 128;
  localparam int AW  = 12;
  localparam int FD  = 4;
  localparam int PWD = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_dec;
  logic [AW:0]     buf_words_avail;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [W-1:0]    mem_rd_data = '0;
  logic [3:0]      ssm_rd_en;
  logic [4*W-1:0]  ssm_data;
  logic [3:0]      ssm_vld;
  logic            busy;
  logic [3:0]      err;

  always #5 clk = ~clk;

  ssm_word_scheduler #(
    .WORD_W      (W),
    .AW          (AW),
    .FIFO_DEPTH  (FD),
    .PRIME_WORDS (PWD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_dec       (start_dec),
    .buf_words_avail (buf_words_avail),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .ssm_rd_en       (ssm_rd_en),
    .ssm_data        (ssm_data),
    .ssm_vld         (ssm_vld),
    .busy            (busy),
    .err             (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Buffer model: word at address a holds value a. Read monitor checks that
  // addresses are issued sequentially from 0 after reset/restart.
  int            rd_cnt   = 0;
  logic [AW-1:0] mon_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      rd_cnt   = 0;
      mon_addr = '0;
    end else begin
      if (mem_rd_en) begin
        check("rd_addr", W'(mem_rd_addr), W'(mon_addr));
        mon_addr = mon_addr + 1'b1;
        rd_cnt++;
      end
      if (start_dec) begin
        rd_cnt   = 0;
        mon_addr = '0;
      end
    end
    if (mem_rd_en) mem_rd_data <= W'(mem_rd_addr);
  end

  // Per-substream expected word order.
  logic [W-1:0] exp_q [4][$];
  int           next_addr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic prime_expect();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    for (int r = 0; r < PWD; r++)
      for (int i = 0; i < 4; i++) exp_q[i].push_back(W'(r * 4 + i));
    next_addr = 4 * PWD;
  endtask

  // Pops in the current cycle; each pop earns the next buffer address,
  // granted in ascending substream order.
  task automatic drive_pops(input logic [3:0] m);
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        e = '1;
        if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
        check($sformatf("pop_vld%0d", i), W'(ssm_vld[i]), W'(1));
        check($sformatf("pop_head%0d", i), ssm_data[i*W +: W], e);
        exp_q[i].push_back(W'(next_addr));
        next_addr++;
      end
    end
    ssm_rd_en = m;
  endtask

  task automatic pop_wait(input logic [3:0] m);
    drive_pops(m);
    tick();
    ssm_rd_en = '0;
    cycles(4);
  endtask

  task automatic check_heads(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_vld%0d", tag, i), W'(ssm_vld[i]), W'(1));
      if (exp_q[i].size() > 0)
        check($sformatf("%s_head%0d", tag, i), ssm_data[i*W +: W], exp_q[i][0]);
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rdcnt"}, W'(rd_cnt), W'(next_addr));
    check({tag, "_addr"}, W'(mem_rd_addr), W'(next_addr % (1 << AW)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_err;
    logic [3:0] m;
    int         k;

    rst = 1'b1; start_dec = 1'b0; buf_words_avail = '0; ssm_rd_en = '0;
    cycles(3);
    check("rst_rd_en", W'(mem_rd_en), W'(0));
    check("rst_addr", W'(mem_rd_addr), W'(0));
    check("rst_vld", W'(ssm_vld), W'(0));
    check("rst_data_nz", W'(|ssm_data), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_err", W'(err), W'(0));
    rst = 1'b0;
    tick();

    // Prime
    buf_words_avail = 13'd100;
    start_dec = 1'b1;
    tick();
    start_dec = 1'b0;
    #1;
    prime_expect();
    check("first_rd", W'(mem_rd_en), W'(1));
    tick();
    check("vld0_early", W'(ssm_vld[0]), W'(0));
    tick();
    check("vld0_rise", W'(ssm_vld[0]), W'(1));
    cycles(10);
    check_heads("prime");
    check_reads("prime");
    check("prime_state", W'(dut.state), W'(RUN));
    check("prime_busy", W'(busy), W'(1));
    check("prime_idle_rd", W'(mem_rd_en), W'(0));

    // Simultaneous pops
    drive_pops(4'b1111);
    tick();
    ssm_rd_en = '0;
    cycles(6);
    check_heads("simul");
    check_reads("simul");

    // Interleaved order: ssm3 then ssm0 on consecutive cycles
    drive_pops(4'b1000);
    tick();
    drive_pops(4'b0001);
    tick();
    ssm_rd_en = '0;
    cycles(5);
    pop_wait(4'b1000);
    pop_wait(4'b1000);
    pop_wait(4'b0001);
    pop_wait(4'b0001);
    check_heads("inter");

    // Random sustained pops
    for (int n = 0; n < 60; n++) begin
      m = 4'($urandom_range(0, 15)) & ssm_vld;
      drive_pops(m);
      tick();
    end
    ssm_rd_en = '0;
    cycles(6);
    check_heads("rand");
    check_reads("rand");

    // Starvation
    buf_words_avail = '0;
    drive_pops(4'b0010);
    tick();
    drive_pops(4'b0010);
    tick();
    ssm_rd_en = '0;
    for (int n = 0; n < 3; n++) begin
      check("starve_no_rd", W'(mem_rd_en), W'(0));
      tick();
    end
    check("starve_vld1", W'(ssm_vld[1]), W'(0));
    buf_words_avail = 13'd1;
    #1;
    k = 0;
    while (!mem_rd_en && k < 3) begin
      tick();
      k++;
    end
    check("starve_rd", W'(mem_rd_en), W'(1));
    tick();
    check("starve_vld1_t1", W'(ssm_vld[1]), W'(0));
    tick();
    check("starve_vld1_t2", W'(ssm_vld[1]), W'(1));
    check("starve_head1", ssm_data[1*W +: W], exp_q[1][0]);
    cycles(5);
    check_reads("starve");
    buf_words_avail = 13'd100;
    cycles(3);
    check_heads("starve");

    // Restart one cycle after a read issues
    drive_pops(4'b0100);
    tick();
    ssm_rd_en = '0;
    #1;
    check("rs_rd", W'(mem_rd_en), W'(1));
    tick();
    start_dec = 1'b1;
    tick();
    start_dec = 1'b0;
    prime_expect();
    cycles(12);
    check_heads("restart");
    check_reads("restart");
    check("restart_err", W'(err), W'(0));
    pop_wait(4'b1111);
    check_heads("restart2");

    // Underflow on ssm2
`ifdef SSM_SCHED_ERR_CHK_EN
    exp_err = 4'b0100;
`else
    exp_err = 4'b0000;
`endif
    buf_words_avail = '0;
    drive_pops(4'b0100);
    tick();
    drive_pops(4'b0100);
    tick();
    ssm_rd_en = '0;
    tick();
    check("uf_vld2", W'(ssm_vld[2]), W'(0));
    ssm_rd_en = 4'b0100;
    tick();
    ssm_rd_en = '0;
    #1;
    check("uf_err", W'(err), W'(exp_err));
    buf_words_avail = 13'd100;
    cycles(6);
    check_reads("uf");
    check_heads("uf");
    check("uf_err_sticky", W'(err), W'(exp_err));
    start_dec = 1'b1;
    tick();
    start_dec = 1'b0;
    #1;
    check("uf_err_clr", W'(err), W'(0));
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
